// File: rtl/rgge_rtl_types_pkg.sv
// Shared register-bus types: access direction, response status and the APB bridge state.
package rgge_rtl_types_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'd0,
    RGGEN_EXOKAY       = 2'd1,
    RGGEN_SLAVE_ERROR  = 2'd2,
    RGGEN_DECODE_ERROR = 2'd3
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } rggen_bridge_state;

  // Wide enough for the largest legal timeout (1023 cycles).
  localparam int unsigned TIMER_WIDTH = 10;

endpackage

// File: rtl/rggen_apb_bridge_timer.sv
// Saturating BUSY-cycle counter; o_expired rises in the TIMEOUT_CYCLES-th counted cycle.
module rggen_apb_bridge_timer
  import rgge_rtl_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam logic [TIMER_WIDTH-1:0] LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] count;

  assign o_expired = (count >= LIMIT);

  // Holds at LIMIT once reached so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_count && !o_expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rggen_apb_bridge.sv
// APB slave to rggen command/response bridge, one access outstanding.
// Define RGGEN_APB_BRIDGE_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES with a slave error.
module rggen_apb_bridge
  import rgge_rtl_types_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic [ADDRESS_WIDTH-1:0] i_paddr,
  input  logic                     i_pwrite,
  input  logic [BUS_WIDTH-1:0]     i_pwdata,
  input  logic [BUS_WIDTH/8-1:0]   i_pstrb,
  output logic                     o_pready,
  output logic [BUS_WIDTH-1:0]     o_prdata,
  output logic                     o_pslverr,
  output logic                     o_command_valid,
  output rggen_direction           o_command_direction,
  output logic [ADDRESS_WIDTH-1:0] o_command_address,
  output logic [BUS_WIDTH-1:0]     o_command_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_command_strobe,
  input  logic                     i_response_valid,
  input  rggen_status              i_response_status,
  input  logic [BUS_WIDTH-1:0]     i_response_read_data
);

  rggen_bridge_state              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]       address_q;
  rggen_direction                 direction_q;
  logic [BUS_WIDTH-1:0]           write_data_q;
  logic [BUS_WIDTH/8-1:0]         strobe_q;
  rggen_status                    status_q;
  logic [BUS_WIDTH-1:0]           read_data_q;
  logic                           setup;
  logic                           busy;
  logic                           timeout;

  assign setup = (state_q == IDLE) && i_psel && !i_penable;
  assign busy  = (state_q == BUSY);

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  rggen_apb_bridge_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (setup),
    .i_count   (busy),
    .o_expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup) state_d = BUSY;
      BUSY:    if (i_response_valid || timeout) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      address_q    <= '0;
      direction_q  <= RGGEN_READ;
      write_data_q <= '0;
      strobe_q     <= '0;
      status_q     <= RGGEN_OKAY;
      read_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (setup) begin
        address_q    <= i_paddr;
        direction_q  <= i_pwrite ? RGGEN_WRITE : RGGEN_READ;
        write_data_q <= i_pwdata;
        strobe_q     <= i_pwrite ? i_pstrb : '1;
      end
      // A response in the expiring cycle takes priority over the timeout.
      if (busy && i_response_valid) begin
        status_q    <= i_response_status;
        read_data_q <= i_response_read_data;
      end else if (busy && timeout) begin
        status_q    <= RGGEN_SLAVE_ERROR;
        read_data_q <= '0;
      end
    end
  end

  assign o_command_valid      = busy;
  assign o_command_direction  = direction_q;
  assign o_command_address    = address_q;
  assign o_command_write_data = write_data_q;
  assign o_command_strobe     = strobe_q;

  assign o_pready  = (state_q == RESPOND);
  assign o_pslverr = o_pready && status_q[1];
  assign o_prdata  = (o_pready && (direction_q == RGGEN_READ) && !status_q[1]) ?
                     read_data_q : '0;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Self-checking bench for rggen_apb_bridge: directed table, reset corner and random accesses.
module tb_rggen_apb_bridge;
  import rgge_rtl_types_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned BW = 32;
  localparam int unsigned TO = 4;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              psel, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [BW-1:0]     pwdata;
  logic [BW/8-1:0]   pstrb;
  logic              pready, pslverr;
  logic [BW-1:0]     prdata;
  logic              cmd_valid;
  rggen_direction    cmd_dir;
  logic [AW-1:0]     cmd_addr;
  logic [BW-1:0]     cmd_wdata;
  logic [BW/8-1:0]   cmd_strb;
  logic              resp_valid;
  rggen_status       resp_status;
  logic [BW-1:0]     resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_psel               (psel),
    .i_penable            (penable),
    .i_paddr              (paddr),
    .i_pwrite             (pwrite),
    .i_pwdata             (pwdata),
    .i_pstrb              (pstrb),
    .o_pready             (pready),
    .o_prdata             (prdata),
    .o_pslverr            (pslverr),
    .o_command_valid      (cmd_valid),
    .o_command_direction  (cmd_dir),
    .o_command_address    (cmd_addr),
    .o_command_write_data (cmd_wdata),
    .o_command_strobe     (cmd_strb),
    .i_response_valid     (resp_valid),
    .i_response_status    (resp_status),
    .i_response_read_data (resp_data)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          delay;   // response arrives in BUSY cycle delay+1
    rggen_status status;
    logic [31:0] rdata;
    int          exp_busy;
    logic        exp_slverr;
    logic [31:0] exp_prdata;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the command stays up until the response or the timeout limit, whichever first.
  function automatic void model(inout vec_t v);
    bit timed_out;
    timed_out    = TIMEOUT_ON && (v.delay + 1 > int'(TO));
    v.exp_busy   = timed_out ? int'(TO) : v.delay + 1;
    v.exp_slverr = timed_out ? 1'b1 : v.status[1];
    v.exp_prdata = (!v.wr && !v.exp_slverr) ? v.rdata : 32'h0;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 64'(cmd_valid), 64'd0);
    check({tag, " pready"}, 64'(pready), 64'd0);
    check({tag, " pslverr"}, 64'(pslverr), 64'd0);
    check({tag, " prdata"}, 64'(prdata), 64'd0);
  endtask

  task automatic run_txn(input vec_t v, input bit drop_psel, input string tag);
    psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
    pwdata = v.wdata; pstrb = v.strb;
    step();
    penable = 1'b1;
    for (int cyc = 1; cyc <= v.exp_busy + 1; cyc++) begin
      if (cyc <= v.exp_busy) begin
        check({tag, " valid"}, 64'(cmd_valid), 64'd1);
        check({tag, " pready_busy"}, 64'(pready), 64'd0);
        check({tag, " addr"}, 64'(cmd_addr), 64'(v.addr));
        check({tag, " dir"}, 64'(cmd_dir), 64'(v.wr));
        check({tag, " wdata"}, 64'(cmd_wdata), 64'(v.wdata));
        check({tag, " strobe"}, 64'(cmd_strb), 64'(v.wr ? v.strb : 4'hF));
        check({tag, " prdata_busy"}, 64'(prdata), 64'd0);
      end else begin
        check({tag, " pready"}, 64'(pready), 64'd1);
        check({tag, " valid_resp"}, 64'(cmd_valid), 64'd0);
        check({tag, " pslverr"}, 64'(pslverr), 64'(v.exp_slverr));
        check({tag, " prdata"}, 64'(prdata), 64'(v.exp_prdata));
      end
      resp_valid  = (cyc == v.delay + 1);
      resp_status = resp_valid ? v.status : rggen_status'($urandom_range(0, 3));
      resp_data   = resp_valid ? v.rdata : $urandom;
      if (drop_psel && cyc == 1) begin
        psel = 1'b0; penable = 1'b0;
      end
      step();
    end
    resp_valid = 1'b0; psel = 1'b0; penable = 1'b0;
    check_idle({tag, " after"});
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; resp_valid = 1'b0; resp_status = RGGEN_OKAY; resp_data = '0;
    step(); step();
    check_idle("reset");
    check("reset addr", 64'(cmd_addr), 64'd0);
    check("reset strobe", 64'(cmd_strb), 64'd0);
    rst = 1'b0;
    step();

    // Idle: non-setup APB phase and stray responses must not start an access.
    psel = 1'b1; penable = 1'b1; resp_valid = 1'b1; resp_data = 32'hCAFE0001;
    step();
    check_idle("idle_noise");
    step();
    check_idle("idle_noise2");
    psel = 1'b0; penable = 1'b0; resp_valid = 1'b0;
    step();

    tbl[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, RGGEN_OKAY, 32'h0,
               1, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 16'h0004, 32'h0, 4'h0, 2, RGGEN_OKAY, 32'h12345678,
               3, 1'b0, 32'h12345678};
    tbl[2] = '{1'b0, 16'h0008, 32'h0, 4'h0, 1, RGGEN_DECODE_ERROR, 32'hFFFFFFFF,
               2, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 16'h000C, 32'h0, 4'h2, 0, RGGEN_EXOKAY, 32'hA5A55A5A,
               1, 1'b0, 32'hA5A55A5A};
    tbl[4] = '{1'b1, 16'h0014, 32'h01020304, 4'h3, 0, RGGEN_SLAVE_ERROR, 32'h77,
               1, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 16'h0018, 32'h0, 4'h0, 3, RGGEN_OKAY, 32'h0BADF00D,
               4, 1'b0, 32'h0BADF00D};
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    tbl[6] = '{1'b0, 16'h001C, 32'h0, 4'h0, 30, RGGEN_OKAY, 32'h11111111,
               4, 1'b1, 32'h0};
`else
    tbl[6] = '{1'b0, 16'h001C, 32'h0, 4'h0, 7, RGGEN_OKAY, 32'h11111111,
               8, 1'b0, 32'h11111111};
`endif
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i], 1'b0, $sformatf("tbl%0d", i));
    end

    // Reset during the 2nd BUSY cycle, then a late response.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0020;
    pwdata = 32'h55AA55AA; pstrb = 4'h5;
    step();
    penable = 1'b1;
    step();
    check("rst_mid valid", 64'(cmd_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    resp_valid = 1'b1; resp_status = RGGEN_OKAY; resp_data = 32'h99999999;
    check_idle("rst_mid");
    check("rst_mid addr", 64'(cmd_addr), 64'd0);
    check("rst_mid strobe", 64'(cmd_strb), 64'd0);
    check("rst_mid dir", 64'(cmd_dir), 64'd0);
    check("rst_mid wdata", 64'(cmd_wdata), 64'd0);
    step();
    resp_valid = 1'b0;
    check_idle("rst_late_resp");
    step();
    check_idle("rst_late_resp2");

    for (int n = 0; n < 40; n++) begin
      rv.wr     = 1'($urandom);
      rv.addr   = 16'($urandom);
      rv.wdata  = $urandom;
      rv.strb   = 4'($urandom);
      rv.delay  = int'($urandom_range(0, 6));
      rv.status = rggen_status'($urandom_range(0, 3));
      rv.rdata  = $urandom;
      model(rv);
      run_txn(rv, 1'($urandom_range(0, 3) == 0), $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        resp_valid = 1'b1; resp_data = $urandom;
        step();
        resp_valid = 1'b0;
        check_idle($sformatf("rnd%0d gap", n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
